// File: rtl/period_meter.sv
// Period / high-time meter for a slow divided clock, counted in system-clock cycles.
// Define PERIOD_SYNC_EN to pass sig_in_i through a two-flop synchronizer (asynchronous inputs).

module period_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e state_q, state_d;

  logic             s_q;
  logic             s_prev_q;
  logic             rise;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             cnt_at_max;
  logic [CNT_W-1:0] s_ext;

  // Control strobes decoded from the FSM
  logic             ctl_clear;
  logic             ctl_start;
  logic             ctl_capture;
  logic             ctl_advance;
  logic             ctl_saturate;

  //--------------------------------------------------------------------------
  // Input sampling; keeps running with en_i low so re-enabling sees no false rise
  //--------------------------------------------------------------------------
`ifdef PERIOD_SYNC_EN
  logic sync1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= sig_in_i;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= sig_in_i;
      s_prev_q <= s_q;
    end
  end
`endif

  assign rise       = s_q & ~s_prev_q;
  assign cnt_at_max = (cnt_q == CntMax);
  assign s_ext      = {{(CNT_W-1){1'b0}}, s_q};

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) state_d = StMeasure;
        end
        StMeasure: begin
          if (!rise && cnt_at_max) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // FSM: control outputs
  //--------------------------------------------------------------------------
  always_comb begin
    ctl_clear    = 1'b0;
    ctl_start    = 1'b0;
    ctl_capture  = 1'b0;
    ctl_advance  = 1'b0;
    ctl_saturate = 1'b0;
    if (!en_i) begin
      ctl_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          ctl_start = rise;
          ctl_clear = ~rise;
        end
        StMeasure: begin
          if (rise) begin
            ctl_capture = 1'b1;
            ctl_start   = 1'b1;
          end else if (cnt_at_max) begin
            ctl_saturate = 1'b1;
          end else begin
            ctl_advance = 1'b1;
          end
        end
        default: ctl_clear = 1'b1;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Datapath next state
  //--------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (ctl_clear || ctl_saturate) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (ctl_start) begin
      // The rise cycle itself is the first cycle of the new period (and is high)
      cnt_d  = CntOne;
      hcnt_d = CntOne;
    end else if (ctl_advance) begin
      cnt_d  = cnt_q + CntOne;
      hcnt_d = hcnt_q + s_ext;
    end

    if (ctl_capture) begin
      period_d  = cnt_q;
      high_d    = hcnt_q;
      valid_d   = 1'b1;
      timeout_d = 1'b0;
    end else if (ctl_saturate) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o    = period_q;
  assign high_time_o = high_q;
  assign valid_o     = valid_q;
  assign timeout_o   = timeout_q;

`ifndef SYNTHESIS
  // Two rises can never be adjacent, so valid is always a single-cycle pulse
  a_valid_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_q |=> !valid_q);
  a_hcnt_le_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hcnt_q <= cnt_q);
`endif

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter: two instances (CNT_W=16 and CNT_W=4) share stimulus and
// are compared every cycle against a timestamp-based reference model.

module tb_period_meter;

`ifdef PERIOD_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sig = 1'b0;

  logic [15:0] p16, h16;
  logic        v16, t16;
  logic [3:0]  p4, h4;
  logic        v4, t4;

  always #5 clk = ~clk;

  period_meter u_dut16 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .sig_in_i    (sig),
    .period_o    (p16),
    .high_time_o (h16),
    .valid_o     (v16),
    .timeout_o   (t16)
  );

  period_meter #(.CNT_W(4)) u_dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .sig_in_i    (sig),
    .period_o    (p4),
    .high_time_o (h4),
    .valid_o     (v4),
    .timeout_o   (t4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the sampled signal is sig delayed by Lat cycles; a measurement spans the
  // cycles between two rise timestamps, high time is the count of sampled-high cycles in it.
  bit md1, ms, msp;
  bit shist[$];
  int cyc = 0;
  bit armed[2];
  int rise_at[2];
  int exp_period[2];
  int exp_high[2];
  bit exp_valid[2];
  bit exp_to[2];
  int maxv[2] = '{65535, 15};

  task automatic model_step();
    bit rise;
    int sum;
    shist.push_back(ms);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        armed[i] = 0; exp_period[i] = 0; exp_high[i] = 0;
        exp_valid[i] = 0; exp_to[i] = 0;
      end
      md1 = 0; ms = 0; msp = 0;
    end else begin
      rise = ms && !msp;
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = 0;
        if (!en) begin
          armed[i] = 0;
        end else if (!armed[i]) begin
          if (rise) begin
            armed[i] = 1;
            rise_at[i] = cyc;
          end
        end else if (rise) begin
          sum = 0;
          for (int k = rise_at[i]; k < cyc; k++) sum += int'(shist[k]);
          exp_period[i] = cyc - rise_at[i];
          exp_high[i] = sum;
          exp_valid[i] = 1;
          exp_to[i] = 0;
          rise_at[i] = cyc;
        end else if (cyc - rise_at[i] == maxv[i]) begin
          exp_to[i] = 1;
          armed[i] = 0;
        end
      end
      msp = ms;
      ms = (Lat == 2) ? md1 : sig;
      md1 = sig;
    end
    cyc++;
  endtask

  task automatic step(input bit e, input bit s, input bit r);
    en = e;
    sig = s;
    rst_n = r;
    @(posedge clk);
    model_step();
    #1;
    check_val("period16", p16, exp_period[0]);
    check_val("high16", h16, exp_high[0]);
    check_val("valid16", v16, exp_valid[0]);
    check_val("timeout16", t16, exp_to[0]);
    check_val("period4", p4, exp_period[1]);
    check_val("high4", h4, exp_high[1]);
    check_val("valid4", v4, exp_valid[1]);
    check_val("timeout4", t4, exp_to[1]);
  endtask

  task automatic wave(input int hi, input int lo, input int reps, input bit e);
    for (int n = 0; n < reps; n++) begin
      for (int k = 0; k < hi; k++) step(e, 1'b1, 1'b1);
      for (int k = 0; k < lo; k++) step(e, 1'b0, 1'b1);
    end
  endtask

  int vcount;

  initial begin
    // Reset with the input toggling
    for (int k = 0; k < 3; k++) step(1'b1, k[0], 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Divide-by-4
    wave(2, 2, 8, 1'b1);
    // Asymmetric 3/7, also counting valid pulses on the wide instance
    vcount = 0;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 10; k++) begin
        step(1'b1, k < 3, 1'b1);
        vcount += int'(v16);
      end
    end
    check_val("asym_valid_count", vcount, 5);

    // Stuck low long enough to time out the narrow instance, then resume period 6
    wave(3, 3, 2, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b1);
    wave(3, 3, 5, 1'b1);

    // Enable dropped across a rise, re-enabled while the input is high
    wave(2, 2, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    wave(2, 2, 4, 1'b1);

    // Single-cycle reset half way through a period-8 input
    wave(4, 4, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    wave(4, 4, 4, 1'b1);

    // Randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin
        step(1'b1, sig, 1'b0);
      end else if (sel < 3) begin
        wave(int'($urandom_range(2, 8)), int'($urandom_range(2, 8)),
             int'($urandom_range(1, 3)), 1'b0);
      end else if (sel < 5) begin
        for (int k = 0; k < int'($urandom_range(14, 40)); k++) step(1'b1, 1'b0, 1'b1);
      end else begin
        wave(int'($urandom_range(2, 12)), int'($urandom_range(2, 12)),
             int'($urandom_range(1, 4)), 1'b1);
      end
    end
    wave(2, 2, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, divided clock (e.g. the output of the frequency-divider blocks) in units of the system clock. It is the receiving end of a divided-clock chain: it samples the divided signal, detects rising edges, counts system-clock cycles between them, and reports each completed measurement with a one-cycle valid strobe. A saturating watchdog flags a stalled or missing input.

## Interface
- CNT_W, 16, width of the period/high-time counters and outputs (≥ 3)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  measurement enable; low forces IDLE
- sig_in  input  1  divided clock under measurement; may be asynchronous to clk
- period  output  CNT_W  clk cycles between the last two rising edges of sig_in
- high_time  output  CNT_W  clk cycles sig_in was high within that period
- valid  output  1  one-cycle pulse: period/high_time just updated
- timeout  output  1  sticky: counter saturated without a rising edge

## Operation
- s = last stage of input sampling (see Configuration); s_prev = s delayed one clk; rise = s & ~s_prev.
- States: IDLE, MEASURE.
- IDLE: cnt, hcnt held at 0. On rise with en=1 → MEASURE, cnt←1, hcnt←1. No valid.
- MEASURE, rise: period←cnt, high_time←hcnt, valid←1, timeout←0, cnt←1, hcnt←1, stay MEASURE.
- MEASURE, no rise: cnt←cnt+1; hcnt←hcnt+1 if s=1.
- Saturation: if cnt = 2^CNT_W−1 and no rise → timeout←1, state→IDLE; period/high_time hold last values. hcnt cannot exceed cnt, so hcnt never overflows.
- en=0 (any state): state→IDLE, cnt/hcnt←0, valid←0; period, high_time, timeout hold. en=0 wins over a simultaneous rise.
- period/high_time change only on a valid cycle.
- s_prev/sampling registers keep running when en=0, so re-enabling while sig_in is high does not create a false rise.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE; period=0, high_time=0, valid=0, timeout=0; cnt, hcnt, all sampling registers = 0. Reset mid-measurement discards the partial count; the first rise after release only arms MEASURE (no valid).
- valid is high exactly one clk cycle per completed measurement; first valid occurs on the second rise after entering MEASURE.
- Latency, sig_in rising to valid high: valid asserted after the 3rd clk edge counting the edge that first samples sig_in=1 (PERIOD_SYNC_EN defined), after the 2nd edge (undefined).
- Resolution: sig_in high and low phases must each be ≥ 2 clk cycles; narrower pulses give unspecified results (no lockup; reset recovers).
- Steady input: period = exact cycle count, jitter ±1 only from asynchronous sampling.

## Configuration
- PERIOD_SYNC_EN defined: sig_in passes through a two-flop synchronizer before s (s = second flop); use for asynchronous sig_in.
- PERIOD_SYNC_EN undefined: s = sig_in registered once; only for sig_in generated synchronously from clk. One cycle less latency; measured values identical.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with sig_in toggling → period=0, high_time=0, valid=0, timeout=0 throughout; after release the first rise produces no valid.
- Divide-by-4: sig_in toggles every 2 clk cycles, en=1 → after the second rise, valid pulses once every 4 cycles with period=4, high_time=2.
- Asymmetric: sig_in high 3, low 7 cycles repeating → period=10, high_time=3 on every valid; valid width exactly 1 cycle.
- Timeout: CNT_W=4, sig_in stuck low after one rise → timeout=1 after cnt reaches 15, state IDLE, period holds prior value; resume sig_in toggling every 3 cycles → second rise gives valid, period=6, timeout cleared.
- Enable: drop en in the same cycle as a rise → no valid, counts cleared; raise en while sig_in high → no measurement until next true rise, then first valid after one further full period.
- Mid-measure reset: assert rst_n=0 for 1 cycle halfway through a period-8 input → outputs 0; next valid reports period=8, not a truncated value.
